// File: rtl/key_event_fifo.sv
// key_event_fifo
//   Turns changes of a debounced 16-key mask into a queue of key events.
//   Each time `en` pulses, the new mask is scanned one key per cycle,
//   in index order 0..15. The scan compares the new mask against the last
//   fully scanned mask. Every key whose state differs pushes one event
//   {pressed, index} into a circular FIFO. The bus side pops events from
//   that FIFO.
//
// Parameters
//   DEPTH     number of FIFO entries (power of two, 2..64)
//
// Ports
//   clk       clock, rising-edge active
//   rst       asynchronous active-high reset
//   key_deb   debounced key mask (1 = pressed), valid when en=1
//   en        one-cycle pulse: key_deb changed
//   rd_en     pop request
//   ovf_clr   clears the sticky overflow flag
//   rd_data   head event {press, index[3:0]}, 5'h00 when empty (show-ahead)
//   empty     no events stored
//   full      DEPTH events stored
//   count     number of stored events
//   overflow  sticky: an event was dropped because the FIFO was full
//   irq       level interrupt, equal to ~empty
module key_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              key_deb,
  input  logic                     en,
  input  logic                     rd_en,
  input  logic                     ovf_clr,
  output logic [4:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  // Scanner state
  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [15:0]    prev_mask_q, prev_mask_d;
  logic [15:0]    cur_mask_q, cur_mask_d;
  logic [15:0]    pend_mask_q, pend_mask_d;
  logic           pend_q, pend_d;

  // FIFO state
  logic [4:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;

  logic           scan_push;
  logic [4:0]     scan_event;
  logic           empty_int;
  logic           full_int;
  logic           do_pop;
  logic           push_ok;
  logic           drop;

  // --------------------------------------------------------------------
  // Scanner: one key per cycle while in SCAN
  // --------------------------------------------------------------------
  assign scan_push  = (state_q == SCAN) && (cur_mask_q[idx_q] != prev_mask_q[idx_q]);
  assign scan_event = {cur_mask_q[idx_q], idx_q};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    prev_mask_d = prev_mask_q;
    cur_mask_d  = cur_mask_q;
    pend_mask_d = pend_mask_q;
    pend_d      = pend_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          cur_mask_d = key_deb;
          idx_d      = 4'd0;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        if (idx_q == 4'd15) begin
          // The reference mask advances even if some events of this
          // scan were dropped, so a lost change is never re-reported.
          prev_mask_d = cur_mask_q;
          idx_d       = 4'd0;
          if (en) begin
            // A mask arriving exactly at completion is newer than any
            // pending one, so it wins and the pending mask is discarded.
            cur_mask_d = key_deb;
            pend_d     = 1'b0;
          end else if (pend_q) begin
            cur_mask_d = pend_mask_q;
            pend_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 4'd1;
          // Only the most recent mask seen during a scan is kept.
          if (en) begin
            pend_mask_d = key_deb;
            pend_d      = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------
  assign empty_int = (count_q == '0);
  assign full_int  = (count_q == FULL_CNT);

  // A pop on an empty FIFO is ignored, even if a push lands on the
  // same edge. A pop on a full FIFO frees the slot for a push on the
  // same edge.
  assign do_pop  = rd_en && !empty_int;
  assign push_ok = scan_push && (!full_int || do_pop);
  assign drop    = scan_push && full_int && !do_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + (AW + 1)'(push_ok) - (AW + 1)'(do_pop);
    overflow_d = overflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // A drop on the same edge as a clear keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      prev_mask_q <= 16'h0000;
      cur_mask_q  <= 16'h0000;
      pend_mask_q <= 16'h0000;
      pend_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      prev_mask_q <= prev_mask_d;
      cur_mask_q  <= cur_mask_d;
      pend_mask_q <= pend_mask_d;
      pend_q      <= pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Event storage needs no reset: the rd_data mux hides stale entries
  // while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= scan_event;
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign rd_data  = empty_int ? 5'h00 : mem[rd_ptr_q];
  assign empty    = empty_int;
  assign full     = full_int;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign irq      = !empty_int;

endmodule

// File: tb/tb_key_event_fifo.sv
// Self-checking bench for key_event_fifo (DEPTH = 8).
// The table-driven part applies one mask per row, lets the scan finish,
// and then drains the FIFO against the expected event list. Hand-written
// sequences cover the following cases:
//   - push latency
//   - overflow and clear priority
//   - en during a scan and en at scan completion
//   - a push and a pop on the same edge
//   - reset in the middle of a scan
module tb_key_event_fifo;

  logic        clk;
  logic        rst;
  logic [15:0] key_deb;
  logic        en;
  logic        rd_en;
  logic        ovf_clr;
  logic [4:0]  rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  key_event_fifo #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_deb  (key_deb),
    .en       (en),
    .rd_en    (rd_en),
    .ovf_clr  (ovf_clr),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic            rst_first;
    logic [15:0]     mask;
    int              n_ev;
    logic [3:0][4:0] ev;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; leaves the bench 1 unit after the
  // edge that samples en (call that edge E0).
  task automatic apply_en(input logic [15:0] mask);
    key_deb = mask;
    en      = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [4:0] exp);
    check(name, 16'(rd_data), 16'(exp));
    rd_en = 1'b1;
    wait_edges(1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    key_deb = 16'h0000;
    en      = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;

    // Table: each row runs after the previous row's state unless rst_first is set.
    vecs[0] = '{1'b1, 16'h0008, 1, {5'h00, 5'h00, 5'h00, 5'h13}};
    vecs[1] = '{1'b1, 16'h8001, 2, {5'h00, 5'h00, 5'h1F, 5'h10}};
    vecs[2] = '{1'b0, 16'h8000, 1, {5'h00, 5'h00, 5'h00, 5'h00}};
    vecs[3] = '{1'b0, 16'h8000, 0, {5'h00, 5'h00, 5'h00, 5'h00}};
    vecs[4] = '{1'b0, 16'h0000, 1, {5'h00, 5'h00, 5'h00, 5'h0F}};
    vecs[5] = '{1'b0, 16'h00A5, 4, {5'h17, 5'h15, 5'h12, 5'h10}};
    vecs[6] = '{1'b0, 16'h0024, 2, {5'h00, 5'h00, 5'h07, 5'h00}};

    // Reset values while rst is held
    #12;
    check("rst_rd_data",  16'(rd_data),  16'h00);
    check("rst_empty",    16'(empty),    16'h1);
    check("rst_full",     16'(full),     16'h0);
    check("rst_count",    16'(count),    16'h0);
    check("rst_overflow", 16'(overflow), 16'h0);
    check("rst_irq",      16'(irq),      16'h0);
    rst = 1'b0;
    wait_edges(1);

    // Table-driven scans
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rst_first) do_reset();
      apply_en(vecs[v].mask);
      wait_edges(16);
      check($sformatf("vec%0d_count", v), 16'(count), 16'(vecs[v].n_ev));
      check($sformatf("vec%0d_irq", v), 16'(irq), 16'(vecs[v].n_ev != 0));
      for (int k = 0; k < vecs[v].n_ev; k++) begin
        pop_check($sformatf("vec%0d_ev%0d", v, k), vecs[v].ev[k]);
      end
      check($sformatf("vec%0d_empty", v), 16'(empty), 16'h1);
      check($sformatf("vec%0d_rd_zero", v), 16'(rd_data), 16'h00);
      $display("[TB] vector %0d mask %h: %0d events", v, vecs[v].mask, vecs[v].n_ev);
    end

    // Latency: key 3 event appears exactly at the 4th edge after en
    do_reset();
    apply_en(16'h0008);
    wait_edges(3);
    check("lat_count_e3", 16'(count), 16'h0);
    wait_edges(1);
    check("lat_count_e4", 16'(count), 16'h1);
    check("lat_irq_e4",   16'(irq),   16'h1);
    check("lat_data_e4",  16'(rd_data), 16'h13);
    wait_edges(12);
    pop_check("lat_pop", 5'h13);
    $display("[TB] latency sequence done");

    // Overflow, drop vs clear priority, then clear
    do_reset();
    apply_en(16'h03FF);
    wait_edges(8);
    check("ovf_count_e8", 16'(count),    16'h8);
    check("ovf_full_e8",  16'(full),     16'h1);
    check("ovf_flag_e8",  16'(overflow), 16'h0);
    ovf_clr = 1'b1;
    wait_edges(1);
    ovf_clr = 1'b0;
    check("ovf_drop_beats_clr", 16'(overflow), 16'h1);
    wait_edges(7);
    check("ovf_count_end", 16'(count),    16'h8);
    check("ovf_flag_end",  16'(overflow), 16'h1);
    for (int i = 0; i < 8; i++) begin
      pop_check($sformatf("ovf_pop%0d", i), {1'b1, 4'(i)});
    end
    check("ovf_empty", 16'(empty), 16'h1);
    ovf_clr = 1'b1;
    wait_edges(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 16'(overflow), 16'h0);
    $display("[TB] overflow sequence done");

    // en five cycles into a scan: rescan reports only key 1
    do_reset();
    apply_en(16'h0001);
    wait_edges(4);
    apply_en(16'h0003);
    wait_edges(27);
    check("pend_count", 16'(count), 16'h2);
    pop_check("pend_ev0", 5'h10);
    pop_check("pend_ev1", 5'h11);
    check("pend_empty", 16'(empty), 16'h1);
    $display("[TB] en-during-scan sequence done");

    // en on the completion edge beats an older pending mask
    do_reset();
    apply_en(16'h0001);
    wait_edges(2);
    apply_en(16'h0002);
    wait_edges(12);
    apply_en(16'h0004);
    wait_edges(24);
    check("prio_count", 16'(count), 16'h3);
    pop_check("prio_ev0", 5'h10);
    pop_check("prio_ev1", 5'h00);
    pop_check("prio_ev2", 5'h12);
    wait_edges(20);
    check("prio_no_rescan", 16'(count), 16'h0);
    $display("[TB] completion-priority sequence done");

    // Push and pop on the same edge while full
    do_reset();
    apply_en(16'h03FF);
    wait_edges(8);
    rd_en = 1'b1;
    wait_edges(1);
    rd_en = 1'b0;
    check("simfull_count", 16'(count),    16'h8);
    check("simfull_ovf",   16'(overflow), 16'h0);
    check("simfull_head",  16'(rd_data),  16'h11);
    wait_edges(7);
    check("simfull_later_drop", 16'(overflow), 16'h1);
    $display("[TB] full push+pop sequence done");

    // Pop on empty is ignored, also when a push lands on the same edge
    do_reset();
    rd_en = 1'b1;
    wait_edges(1);
    rd_en = 1'b0;
    check("popempty_count", 16'(count), 16'h0);
    apply_en(16'h0001);
    rd_en = 1'b1;
    wait_edges(1);
    rd_en = 1'b0;
    check("simempty_count", 16'(count),   16'h1);
    check("simempty_data",  16'(rd_data), 16'h10);
    wait_edges(15);
    $display("[TB] empty push+pop sequence done");

    // Reset in the middle of a full-mask scan
    do_reset();
    apply_en(16'hFFFF);
    wait_edges(5);
    check("midrst_count_before", 16'(count), 16'h5);
    rst = 1'b1;
    #1;
    check("midrst_count",    16'(count),    16'h0);
    check("midrst_empty",    16'(empty),    16'h1);
    check("midrst_full",     16'(full),     16'h0);
    check("midrst_overflow", 16'(overflow), 16'h0);
    check("midrst_irq",      16'(irq),      16'h0);
    check("midrst_rd_data",  16'(rd_data),  16'h00);
    #1;
    rst = 1'b0;
    apply_en(16'h0001);
    wait_edges(16);
    check("midrst_after_count", 16'(count), 16'h1);
    pop_check("midrst_after_ev", 5'h10);
    check("midrst_after_empty", 16'(empty), 16'h1);
    $display("[TB] mid-scan reset sequence done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 Parameter: DEPTH, default 8, number of event entries; SHALL be a power of two, 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: key_deb  input  16  debounced key mask, 1 = key pressed, bit n = key n.
REQ-005 Port: en  input  1  one-cycle pulse, key_deb changed; key_deb is valid in the same cycle.
REQ-006 Port: rd_en  input  1  pop request from the bus side.
REQ-007 Port: ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 Port: rd_data  output  5  head event: [4] 1 = press / 0 = release, [3:0] key index.
REQ-009 Port: empty  output  1  FIFO holds no events.
REQ-010 Port: full  output  1  FIFO holds DEPTH events.
REQ-011 Port: count  output  log2(DEPTH)+1  number of stored events.
REQ-012 Port: overflow  output  1  sticky; set when an event is dropped.
REQ-013 Port: irq  output  1  level interrupt, equal to ~empty.

Function
REQ-014 Registers: prev_mask (last fully scanned mask), cur_mask (mask being scanned), pend_mask, pend flag, 4-bit scan index, FSM state.
REQ-015 FSM states: IDLE and SCAN only.
REQ-016 IDLE with en=1 at an edge: cur_mask <= key_deb, index <= 0, go to SCAN.
REQ-017 SCAN, one cycle per index: if cur_mask[i] != prev_mask[i], push event {cur_mask[i], i}; otherwise no push.
REQ-018 Timing: the event for index i is pushed at the (i+1)th edge after the edge that sampled en; a scan lasts 16 cycles.
REQ-019 Ordering: events are queued in ascending index order within a scan.
REQ-020 SCAN with index 15 completes as follows:
  - prev_mask <= cur_mask.
  - If pend=1: cur_mask <= pend_mask, pend <= 0, index <= 0, stay in SCAN.
  - Otherwise go to IDLE.
REQ-021 en=1 during SCAN: pend_mask <= key_deb, pend <= 1.
  - A later en before the rescan starts overwrites pend_mask; only the latest mask is scanned.
REQ-022 en=1 on the same edge as the index-15 completion: that en's key_deb is scanned next.
  - It takes priority over any older pend_mask.
REQ-023 A scan with no differing bits pushes nothing and still takes 16 cycles.
REQ-024 FIFO is circular: write and read pointers wrap modulo DEPTH.
  - count = DEPTH SHALL assert full; count = 0 SHALL assert empty.
REQ-025 rd_data is show-ahead: it shows the head entry combinationally from storage and SHALL read 5'h00 when empty.
REQ-026 rd_en=1 with empty=0 pops the head at the edge; rd_en=1 with empty=1 is ignored, with no pointer or count change.
REQ-027 A push with full=0 is stored.
  - A push with full=1 and no pop on that edge is dropped; overflow <= 1.
REQ-028 Push and pop on the same edge:
  - count is unchanged.
  - When full, the push is accepted because the pop frees the slot.
  - When empty, the push is stored and the pop is ignored.
REQ-029 overflow is cleared by ovf_clr=1.
  - If a drop and ovf_clr=1 occur on the same edge, overflow SHALL remain 1.
REQ-030 prev_mask advances even when events of that scan were dropped, so dropped changes are not re-reported.

Reset
REQ-031 rst=1 SHALL immediately force the following, without waiting for a clock edge:
  - FSM to IDLE.
  - index, prev_mask, cur_mask, pend_mask and pend to 0.
  - Read and write pointers to 0.
REQ-032 Reset outputs: rd_data=5'h00, empty=1, full=0, count=0, overflow=0, irq=0.
REQ-033 Reset during SCAN aborts the scan; its unpushed events are lost and stored events are discarded.
REQ-034 After rst deasserts, the first en is compared against an all-released (0) prev_mask.

Verification
REQ-035 Press key 3 only: en with key_deb=16'h0008 -> one event 5'h13 pushed 4 edges after the en edge; count=1, irq=1.
REQ-036 Press and release: press keys 0 and 15 (16'h8001), then release key 0 (16'h8000) -> FIFO reads 5'h10, 5'h1F, 5'h00 in that order, then empty=1, rd_data=5'h00.
REQ-037 Overflow with DEPTH=8: en with 16'h03FF (10 presses), no reads -> count=8, full=1, overflow=1; the 8 reads return indices 0..7; ovf_clr then clears overflow.
REQ-038 en during scan: en 16'h0001, then en 16'h0003 five cycles later -> events 5'h10 then 5'h11; no duplicate for key 0.
REQ-039 Simultaneous events: with full=1, hold rd_en=1 during a push -> count stays 8, no overflow; with empty=1, rd_en during a push -> count=1.
REQ-040 Reset mid-scan: assert rst at index 5 of a 16'hFFFF scan -> all outputs at reset values; the next en with 16'h0001 yields only 5'h10.
